// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC and picks next PC from trap/JALR/branch/stall/sequential.
// Latency: registered PC, any redirect is visible on pc_out one cycle after it is presented.
// Backpressure: stall holds the PC unless a redirect is active; RAS push/pop ignore stall.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   stall                           hold PC (lowest-priority source below redirects)
//   br_taken/br_target              conditional branch or JAL redirect
//   jalr_en/jalr_target             JALR redirect (bit0 already cleared)
//   trap_en/trap_vector             trap redirect, never alignment-checked
//   pc_out, pc_plus                 current fetch PC and PC + INSTR_BYTES (mod 2^XLEN)
//   misalign_exc, misalign_addr     1-cycle pulse and held address of a rejected target
//   ras_push/ras_pop/ras_top/ras_empty/ras_full
//                                   return-address stack, present only when the
//                                   PC_UNIT_RAS_EN macro is defined
module pc_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                INSTR_BYTES  = 4,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
`ifdef PC_UNIT_RAS_EN
    ,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full
`endif
);

    // Elaboration-time parameter sanity checks.
    if (XLEN < 16) begin : g_bad_xlen
        $error("pc_unit: XLEN must be >= 16");
    end
    if (INSTR_BYTES != 2 && INSTR_BYTES != 4) begin : g_bad_instr
        $error("pc_unit: INSTR_BYTES must be 2 or 4");
    end
    if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras
        $error("pc_unit: RAS_DEPTH must be a power of two in 2..16");
    end

    function automatic logic is_misaligned(input logic [XLEN-1:0] t);
        if (INSTR_BYTES == 4) return t[1] | t[0];
        else                  return t[0];
    endfunction

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            exc_next;
    logic [XLEN-1:0] exc_addr_next;

    assign pc_out  = pc_q;
    assign pc_plus = pc_q + XLEN'(INSTR_BYTES);

    // A misaligned redirect blocks the PC outright: falling through to a
    // lower-priority source would fetch from a path the program never took.
    always_comb begin
        pc_next       = pc_plus;
        exc_next      = 1'b0;
        exc_addr_next = misalign_addr;
        if (trap_en) begin
            pc_next = trap_vector;
        end else if (jalr_en) begin
            if (is_misaligned(jalr_target)) begin
                pc_next       = pc_q;
                exc_next      = 1'b1;
                exc_addr_next = jalr_target;
            end else begin
                pc_next = jalr_target;
            end
        end else if (br_taken) begin
            if (is_misaligned(br_target)) begin
                pc_next       = pc_q;
                exc_next      = 1'b1;
                exc_addr_next = br_target;
            end else begin
                pc_next = br_target;
            end
        end else if (stall) begin
            pc_next = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            pc_q          <= pc_next;
            misalign_exc  <= exc_next;
            misalign_addr <= exc_addr_next;
        end
    end

`ifdef PC_UNIT_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr, ras_ptr_n;   // index of the top entry
    logic [CW-1:0]   ras_cnt, ras_cnt_n;
    logic            mem_we;
    logic [PW-1:0]   mem_wa;

    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem[ras_ptr];

    // Circular buffer: a push past full simply advances over the oldest
    // entry, so the count saturates while the pointer keeps wrapping.
    always_comb begin
        ras_ptr_n = ras_ptr;
        ras_cnt_n = ras_cnt;
        mem_we    = 1'b0;
        mem_wa    = ras_ptr + PW'(1);
        if (trap_en) begin
            ras_cnt_n = '0;
        end else if (ras_push && ras_pop && !ras_empty) begin
            mem_we = 1'b1;
            mem_wa = ras_ptr;
        end else if (ras_push) begin
            mem_we    = 1'b1;
            ras_ptr_n = ras_ptr + PW'(1);
            if (!ras_full) ras_cnt_n = ras_cnt + CW'(1);
        end else if (ras_pop && !ras_empty) begin
            ras_ptr_n = ras_ptr - PW'(1);
            ras_cnt_n = ras_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else begin
            ras_ptr <= ras_ptr_n;
            ras_cnt <= ras_cnt_n;
        end
    end

    // Storage is not reset; entries are only visible through the count.
    always_ff @(posedge clk) begin
        if (mem_we) ras_mem[mem_wa] <= pc_plus;
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br_taken, jalr_en, trap_en;
    logic [31:0] br_target, jalr_target, trap_vector;
    logic [31:0] pc_out, pc_plus, misalign_addr;
    logic        misalign_exc;
    logic        ras_push, ras_pop, ras_empty, ras_full;
    logic [31:0] ras_top;

    int total  = 0;
    int passed = 0;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .INSTR_BYTES  (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .jalr_en       (jalr_en),
        .jalr_target   (jalr_target),
        .trap_en       (trap_en),
        .trap_vector   (trap_vector),
        .pc_out        (pc_out),
        .pc_plus       (pc_plus),
        .misalign_exc  (misalign_exc),
        .misalign_addr (misalign_addr)
`ifdef PC_UNIT_RAS_EN
        ,
        .ras_push      (ras_push),
        .ras_pop       (ras_pop),
        .ras_top       (ras_top),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle();
        stall = 0; br_taken = 0; jalr_en = 0; trap_en = 0;
        br_target = '0; jalr_target = '0; trap_vector = '0;
        ras_push = 0; ras_pop = 0;
    endtask

    // One rising edge, then sample 1 time unit later; inputs return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic jump(input logic [31:0] t);
        jalr_en = 1; jalr_target = t;
        tick();
    endtask

    initial begin
        idle();
        rst = 1;
        #12;
        rst = 0;
        @(posedge clk); #1;

        // 1: reset value, async reset mid-cycle, sequential fetch
        check("post_reset_pc", pc_out, 32'h104);
        check("reset_exc", {31'b0, misalign_exc}, 32'h0);
        check("reset_addr", misalign_addr, 32'h0);
        #2 rst = 1;
        #1;
        check("async_reset_pc", pc_out, 32'h100);
        #1 rst = 0;
        tick(); check("seq_1", pc_out, 32'h104);
        tick(); check("seq_2", pc_out, 32'h108);
        tick(); check("seq_3", pc_out, 32'h10C);
        check("pc_plus", pc_plus, 32'h110);

        // 2: priority
        jump(32'h200);
        check("jalr_200", pc_out, 32'h200);
        trap_en = 1; trap_vector = 32'h800;
        jalr_en = 1; jalr_target = 32'h400;
        br_taken = 1; br_target = 32'h300;
        stall = 1;
        tick(); check("prio_trap", pc_out, 32'h800);
        stall = 1;
        tick(); check("stall_hold", pc_out, 32'h800);
        br_taken = 1; br_target = 32'h300; stall = 1;
        tick(); check("br_over_stall", pc_out, 32'h300);

        // 3: misaligned branch
        jump(32'h40);
        br_taken = 1; br_target = 32'h1002;
        tick();
        check("mis_pc_hold", pc_out, 32'h40);
        check("mis_exc", {31'b0, misalign_exc}, 32'h1);
        check("mis_addr", misalign_addr, 32'h1002);
        tick();
        check("mis_after_pc", pc_out, 32'h44);
        check("mis_exc_clear", {31'b0, misalign_exc}, 32'h0);
        check("mis_addr_held", misalign_addr, 32'h1002);

        // misaligned JALR: valid lower-priority branch must not be taken
        jalr_en = 1; jalr_target = 32'h2002;
        br_taken = 1; br_target = 32'h300;
        tick();
        check("mis_jalr_pc", pc_out, 32'h44);
        check("mis_jalr_exc", {31'b0, misalign_exc}, 32'h1);
        check("mis_jalr_addr", misalign_addr, 32'h2002);
        // trap vector is never alignment-checked
        trap_en = 1; trap_vector = 32'h803;
        tick();
        check("trap_unchecked_pc", pc_out, 32'h803);
        check("trap_unchecked_exc", {31'b0, misalign_exc}, 32'h0);

        // 4: wrap
        jump(32'hFFFF_FFFC);
        check("wrap_pc_plus", pc_plus, 32'h0);
        tick();
        check("wrap_pc", pc_out, 32'h0);
        check("wrap_exc", {31'b0, misalign_exc}, 32'h0);

`ifdef PC_UNIT_RAS_EN
        // 5: RAS fill, overflow, drain, underflow
        jump(32'h10);
        check("ras_reset_empty", {31'b0, ras_empty}, 32'h1);
        check("ras_reset_top", ras_top, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            ras_push = 1; jalr_en = 1; jalr_target = 32'((i + 1) * 16);
            tick();
        end
        check("ras_full", {31'b0, ras_full}, 32'h1);
        check("ras_pc_after_push", pc_out, 32'h60);
        check("ras_pop0", ras_top, 32'h54); ras_pop = 1; stall = 1; tick();
        check("ras_not_full", {31'b0, ras_full}, 32'h0);
        check("ras_pop1", ras_top, 32'h44); ras_pop = 1; stall = 1; tick();
        check("ras_pop2", ras_top, 32'h34); ras_pop = 1; stall = 1; tick();
        check("ras_pop3", ras_top, 32'h24); ras_pop = 1; stall = 1; tick();
        check("ras_drained_empty", {31'b0, ras_empty}, 32'h1);
        check("ras_drained_top", ras_top, 32'h0);
        ras_pop = 1; stall = 1; tick();
        check("ras_underflow_empty", {31'b0, ras_empty}, 32'h1);
        check("ras_underflow_top", ras_top, 32'h0);
        check("ras_stall_pc", pc_out, 32'h60);

        // 6: push+pop replaces top; trap flushes
        jump(32'h20);
        ras_push = 1; stall = 1; tick();
        check("ras_top_24", ras_top, 32'h24);
        jump(32'h60);
        ras_push = 1; ras_pop = 1; stall = 1; tick();
        check("ras_pushpop_top", ras_top, 32'h64);
        check("ras_pushpop_cnt", {31'b0, ras_empty}, 32'h0);
        ras_pop = 1; stall = 1; tick();
        check("ras_pushpop_one", {31'b0, ras_empty}, 32'h1);
        ras_push = 1; stall = 1; tick();
        trap_en = 1; trap_vector = 32'h900; ras_push = 1;
        tick();
        check("ras_trap_flush", {31'b0, ras_empty}, 32'h1);
        check("ras_trap_top", ras_top, 32'h0);
        check("ras_trap_pc", pc_out, 32'h900);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
